// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM pipeline hazard logic.
// Scoreboard slots hold destination addresses zero-extended to SB_DEST_W, so RA_W may not exceed it.
package arm_pipe_pkg;

  localparam int unsigned SB_DEST_W = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    FREEZE = 2'd3
  } pipe_state_e;

  typedef struct packed {
    logic                 v;
    logic [SB_DEST_W-1:0] dest;
    logic                 ld;
  } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_sb_match.sv
// One scoreboard slot against one source register.
// With ld_only set, only a load in the slot can hit (forwarding covers everything else).
module sb_match
  import arm_pipe_pkg::*;
#(
  parameter int unsigned RA_W = 4
) (
  input  sb_entry_t        slot,
  input  logic [RA_W-1:0]  src,
  input  logic             ld_only,
  output logic             hit
);

  assign hit = slot.v && (slot.ld || !ld_only) && (slot.dest == SB_DEST_W'(src));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flush sequencer: EXE/MEM destination scoreboard, RAW detection against ID sources,
// branch flush, memory-wait freeze and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int unsigned RA_W    = 4,
  parameter int unsigned CNT_W   = 16,
  parameter logic        FWD_RST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_src1,
  input  logic [RA_W-1:0]  id_src2,
  input  logic             id_two_src,
  input  logic             id_wb_en,
  input  logic [RA_W-1:0]  id_dest,
  input  logic             id_mem_r_en,
  input  logic             exe_br_taken,
  input  logic             mem_stall,
  input  logic             fwd_set,
  input  logic             fwd_val,
  input  logic             cnt_clr,
  output logic             hazard,
  output logic             freeze_if,
  output logic             flush_if,
  output logic             flush_id,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  sb_entry_t        e0, e1, e0_nxt, e1_nxt;
  logic             fwd_en;
  pipe_state_e      state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q;

  logic hit_e0_s1, hit_e0_s2, hit_e1_s1, hit_e1_s2;
  logic match1, match2, raw;
  logic hazard_c, freeze_c, flush_c;

  sb_match #(.RA_W(RA_W)) u_e0_s1 (.slot(e0), .src(id_src1), .ld_only(fwd_en), .hit(hit_e0_s1));
  sb_match #(.RA_W(RA_W)) u_e0_s2 (.slot(e0), .src(id_src2), .ld_only(fwd_en), .hit(hit_e0_s2));
  sb_match #(.RA_W(RA_W)) u_e1_s1 (.slot(e1), .src(id_src1), .ld_only(fwd_en), .hit(hit_e1_s1));
  sb_match #(.RA_W(RA_W)) u_e1_s2 (.slot(e1), .src(id_src2), .ld_only(fwd_en), .hit(hit_e1_s2));

  // The MEM slot only matters without forwarding; a load there is already forwardable.
  always_comb begin
    match1 = hit_e0_s1 || (!fwd_en && hit_e1_s1);
    match2 = hit_e0_s2 || (!fwd_en && hit_e1_s2);
    raw    = id_valid && (match1 || (id_two_src && match2));
  end

  always_comb begin
    hazard_c  = 1'b0;
    freeze_c  = 1'b0;
    flush_c   = 1'b0;
    state_nxt = RUN;
    e1_nxt    = e0;
    e0_nxt    = '{v: id_valid && id_wb_en, dest: SB_DEST_W'(id_dest), ld: id_mem_r_en};
    if (mem_stall) begin
      freeze_c  = 1'b1;
      state_nxt = FREEZE;
      e0_nxt    = e0;
      e1_nxt    = e1;
    end else if (exe_br_taken) begin
      flush_c   = 1'b1;
      state_nxt = FLUSH;
      e0_nxt    = '0;
    end else if (raw) begin
      hazard_c  = 1'b1;
      freeze_c  = 1'b1;
      state_nxt = STALL;
      e0_nxt    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      e0      <= '0;
      e1      <= '0;
      fwd_en  <= FWD_RST;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      e0      <= e0_nxt;
      e1      <= e1_nxt;
      state_q <= state_nxt;
      if (!mem_stall && fwd_set) fwd_en <= fwd_val;
      if (cnt_clr)                      cnt_q <= '0;
      else if (hazard_c && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    hazard    = rst && hazard_c;
    freeze_if = rst && freeze_c;
    flush_if  = rst && flush_c;
    flush_id  = rst && flush_c;
    state     = rst ? state_q : RUN;
    stall_cnt = rst ? cnt_q : '0;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a vector table of inputs and hand-computed outputs,
// then a hand-written counter saturation/clear sequence. CNT_W is shrunk to 3 bits.
module tb_pipe_hazard_ctrl;

  localparam int unsigned RA_W  = 4;
  localparam int unsigned CNT_W = 3;

  logic clk = 1'b0;
  logic rst, id_valid, id_two_src, id_wb_en, id_mem_r_en;
  logic exe_br_taken, mem_stall, fwd_set, fwd_val, cnt_clr;
  logic [RA_W-1:0] id_src1, id_src2, id_dest;
  logic hazard, freeze_if, flush_if, flush_id;
  logic [1:0] state;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W), .FWD_RST(1'b0)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_r_en(id_mem_r_en),
    .exe_br_taken(exe_br_taken), .mem_stall(mem_stall), .fwd_set(fwd_set), .fwd_val(fwd_val),
    .cnt_clr(cnt_clr), .hazard(hazard), .freeze_if(freeze_if), .flush_if(flush_if),
    .flush_id(flush_id), .state(state), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic rst, v;
    logic [RA_W-1:0] s1, s2;
    logic two, wb;
    logic [RA_W-1:0] d;
    logic ld, br, ms, fs, fv, clr;
    logic hz, fz, fi, fd;
    logic [1:0] st;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst_i, v, input int s1, s2, input logic two, wb,
                              input int d, input logic ld, br, ms, fs, fv, clr,
                              input logic hz, fz, fi, fd, input int st, cnt);
    vec_t r;
    r.rst = rst_i; r.v = v; r.s1 = RA_W'(s1); r.s2 = RA_W'(s2); r.two = two; r.wb = wb;
    r.d = RA_W'(d); r.ld = ld; r.br = br; r.ms = ms; r.fs = fs; r.fv = fv; r.clr = clr;
    r.hz = hz; r.fz = fz; r.fi = fi; r.fd = fd; r.st = 2'(st); r.cnt = CNT_W'(cnt);
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d want %0d", name, idx, act, exp);
    end
  endtask

  task automatic run_row(input vec_t r, input int idx);
    @(negedge clk);
    rst = r.rst; id_valid = r.v; id_src1 = r.s1; id_src2 = r.s2; id_two_src = r.two;
    id_wb_en = r.wb; id_dest = r.d; id_mem_r_en = r.ld; exe_br_taken = r.br;
    mem_stall = r.ms; fwd_set = r.fs; fwd_val = r.fv; cnt_clr = r.clr;
    #2;
    chk("hazard",    idx, int'(hazard),    int'(r.hz));
    chk("freeze_if", idx, int'(freeze_if), int'(r.fz));
    chk("flush_if",  idx, int'(flush_if),  int'(r.fi));
    chk("flush_id",  idx, int'(flush_id),  int'(r.fd));
    chk("state",     idx, int'(state),     int'(r.st));
    chk("stall_cnt", idx, int'(stall_cnt), int'(r.cnt));
  endtask

  function automatic int sat_inc(input int c);
    return (c == (1 << CNT_W) - 1) ? c : c + 1;
  endfunction

  initial begin
    int exp_cnt;
    int step;
    rst = 1'b0; id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_two_src = 1'b0;
    id_wb_en = 1'b0; id_dest = '0; id_mem_r_en = 1'b0; exe_br_taken = 1'b0;
    mem_stall = 1'b0; fwd_set = 1'b0; fwd_val = 1'b0; cnt_clr = 1'b0;

    // cols: rst v s1 s2 two wb d ld | br ms fs fv clr | hz fz fi fd st cnt
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
    // no forwarding: back-to-back dependence, two stalls
    tbl.push_back(mk(1,1,2,3,1,1,1,0, 0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,1,1,3,1,1,2,0, 0,0,0,0,0, 1,1,0,0,0,0));
    tbl.push_back(mk(1,1,1,3,1,1,2,0, 0,0,0,0,0, 1,1,0,0,1,1));
    tbl.push_back(mk(1,1,1,3,1,1,2,0, 0,0,0,0,0, 0,0,0,0,1,2));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,2));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,2));
    // producer already in MEM: one stall
    tbl.push_back(mk(1,1,2,3,1,1,1,0, 0,0,0,0,0, 0,0,0,0,0,2));
    tbl.push_back(mk(1,1,5,6,1,0,0,0, 0,0,0,0,0, 0,0,0,0,0,2));
    tbl.push_back(mk(1,1,1,3,1,1,2,0, 0,0,0,0,0, 1,1,0,0,0,2));
    tbl.push_back(mk(1,1,1,3,1,1,2,0, 0,0,0,0,0, 0,0,0,0,1,3));
    // src2 only counts with two_src
    tbl.push_back(mk(1,1,7,2,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,3));
    tbl.push_back(mk(1,1,7,2,1,0,0,0, 0,0,0,0,0, 1,1,0,0,0,3));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,1,4));
    // forwarding on: load-use one stall, ALU dependence none
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,1,1,0, 0,0,0,0,0,4));
    tbl.push_back(mk(1,1,8,0,0,1,4,1, 0,0,0,0,0, 0,0,0,0,0,4));
    tbl.push_back(mk(1,1,4,0,0,1,5,0, 0,0,0,0,0, 1,1,0,0,0,4));
    tbl.push_back(mk(1,1,4,0,0,1,5,0, 0,0,0,0,0, 0,0,0,0,1,5));
    tbl.push_back(mk(1,1,9,10,1,1,1,0, 0,0,0,0,0, 0,0,0,0,0,5));
    tbl.push_back(mk(1,1,1,3,1,1,2,0, 0,0,0,0,0, 0,0,0,0,0,5));
    // taken branch beats a load-use hazard and must not capture the ID load
    tbl.push_back(mk(1,1,8,0,0,1,4,1, 0,0,0,0,0, 0,0,0,0,0,5));
    tbl.push_back(mk(1,1,4,0,0,1,4,1, 1,0,0,0,0, 0,0,1,1,0,5));
    tbl.push_back(mk(1,1,4,0,0,1,5,0, 0,0,0,0,0, 0,0,0,0,2,5));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,1,0,1, 0,0,0,0,0,5));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
    // memory freeze over a pending RAW; branch and fwd_set ignored while frozen
    tbl.push_back(mk(1,1,2,3,1,1,1,0, 0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,1,1,3,1,1,2,0, 1,1,1,1,0, 0,1,0,0,0,0));
    tbl.push_back(mk(1,1,1,3,1,1,2,0, 0,1,0,0,0, 0,1,0,0,3,0));
    tbl.push_back(mk(1,1,1,3,1,1,2,0, 0,1,0,0,0, 0,1,0,0,3,0));
    tbl.push_back(mk(1,1,1,3,1,1,2,0, 0,0,0,0,0, 1,1,0,0,3,0));
    tbl.push_back(mk(1,1,1,3,1,1,2,0, 0,0,0,0,0, 1,1,0,0,1,1));
    tbl.push_back(mk(1,1,1,3,1,1,2,0, 0,0,0,0,0, 0,0,0,0,1,2));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,2));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,1, 0,0,0,0,0,2));
    // reset during a load-use stall with forwarding on
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,1,1,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,1,8,0,0,1,4,1, 0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,1,4,0,0,1,5,0, 0,0,0,0,0, 1,1,0,0,0,0));
    tbl.push_back(mk(0,1,4,0,0,1,5,0, 0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,1,4,3,1,1,1,0, 0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(1,1,1,3,1,1,2,0, 0,0,0,0,0, 1,1,0,0,0,0));
    tbl.push_back(mk(1,1,1,3,1,1,2,0, 0,0,0,0,0, 1,1,0,0,1,1));
    tbl.push_back(mk(1,1,1,3,1,1,2,0, 0,0,0,0,0, 0,0,0,0,1,2));

    foreach (tbl[i]) run_row(tbl[i], i);

    // counter saturation: repeated producer/consumer pairs, two stalls each
    step = 100;
    run_row(mk(1,0,0,0,0,0,0,0, 0,0,0,0,1, 0,0,0,0,0,2), step++);
    exp_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      run_row(mk(1,1,9,9,1,1,1,0, 0,0,0,0,0, 0,0,0,0,0,exp_cnt), step++);
      run_row(mk(1,1,1,3,1,1,2,0, 0,0,0,0,0, 1,1,0,0,0,exp_cnt), step++);
      exp_cnt = sat_inc(exp_cnt);
      run_row(mk(1,1,1,3,1,1,2,0, 0,0,0,0,0, 1,1,0,0,1,exp_cnt), step++);
      exp_cnt = sat_inc(exp_cnt);
      run_row(mk(1,1,1,3,1,1,2,0, 0,0,0,0,0, 0,0,0,0,1,exp_cnt), step++);
    end
    chk("saturated", step, int'(stall_cnt), 7);

    // clear wins over a simultaneous increment
    run_row(mk(1,1,9,9,1,1,1,0, 0,0,0,0,0, 0,0,0,0,0,7), step++);
    run_row(mk(1,1,1,3,1,1,2,0, 0,0,0,0,1, 1,1,0,0,0,7), step++);
    run_row(mk(1,1,1,3,1,1,2,0, 0,0,0,0,0, 1,1,0,0,1,0), step++);
    run_row(mk(1,1,1,3,1,1,2,0, 0,0,0,0,0, 0,0,0,0,1,1), step++);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
